// File: rtl/bcd_updown_counter_2d_pkg.sv
// Shared BCD digit definitions, counter payload type and button-command decode
// for the two-digit up/down counter.
package bcd_updown_counter_2d_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] DIG_MAX = 4'd9;
    localparam logic [BCD_W-1:0] DIG_MIN = 4'd0;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } bcd2_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_UP   = 2'd2,
        OP_DN   = 2'd3
    } op_e;

    // Clear wins over everything; up and down together cancel out.
    function automatic op_e decode_op(input logic clr, input logic up, input logic dn);
        op_e op;
        op = OP_HOLD;
        if (clr)            op = OP_CLR;
        else if (up && dn)  op = OP_HOLD;
        else if (up)        op = OP_UP;
        else if (dn)        op = OP_DN;
        return op;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw push-button; emits a
// single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_c_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample agreeing with the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) stable_d = s2_q;
            else                                 cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= btn_i;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press_c_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/bcd_updown_counter_2d.sv
// Two-digit BCD up/down counter fed by debounced push-buttons, with one-cycle
// wrap/borrow pulses at the MAX_VAL/0 boundaries.
module bcd_updown_counter_2d
    import bcd_updown_counter_2d_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned MAX_VAL    = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             btn_clr,
    output logic [BCD_W-1:0] bcd1,
    output logic [BCD_W-1:0] bcd0,
    output logic             wrap,
    output logic             borrow
);

    localparam logic [BCD_W-1:0] MAX_TENS  = BCD_W'(MAX_VAL / 10);
    localparam logic [BCD_W-1:0] MAX_UNITS = BCD_W'(MAX_VAL % 10);

    logic  up_press_c;
    logic  dn_press_c;
    logic  clr_press_c;
    op_e   op_c;
    bcd2_t value_q;
    bcd2_t value_d;
    logic  wrap_q;
    logic  wrap_d;
    logic  borrow_q;
    logic  borrow_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst), .btn_i(btn_up), .press_c_o(up_press_c)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk(clk), .rst(rst), .btn_i(btn_dn), .press_c_o(dn_press_c)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst(rst), .btn_i(btn_clr), .press_c_o(clr_press_c)
    );

    assign op_c = decode_op(clr_press_c, up_press_c, dn_press_c);

    // Digit-wise BCD step; the terminal values are compared per digit.
    always_comb begin
        value_d  = value_q;
        wrap_d   = 1'b0;
        borrow_d = 1'b0;
        case (op_c)
            OP_CLR: value_d = '0;
            OP_UP: begin
                if (value_q.tens == MAX_TENS && value_q.units == MAX_UNITS) begin
                    value_d = '0;
                    wrap_d  = 1'b1;
                end else if (value_q.units == DIG_MAX) begin
                    value_d.units = DIG_MIN;
                    value_d.tens  = value_q.tens + BCD_W'(1);
                end else begin
                    value_d.units = value_q.units + BCD_W'(1);
                end
            end
            OP_DN: begin
                if (value_q.tens == DIG_MIN && value_q.units == DIG_MIN) begin
                    value_d.tens  = MAX_TENS;
                    value_d.units = MAX_UNITS;
                    borrow_d      = 1'b1;
                end else if (value_q.units == DIG_MIN) begin
                    value_d.units = DIG_MAX;
                    value_d.tens  = value_q.tens - BCD_W'(1);
                end else begin
                    value_d.units = value_q.units - BCD_W'(1);
                end
            end
            default: value_d = value_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q  <= '0;
            wrap_q   <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            wrap_q   <= wrap_d;
            borrow_q <= borrow_d;
        end
    end

    assign bcd1   = value_q.tens;
    assign bcd0   = value_q.units;
    assign wrap   = wrap_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_updown_counter_2d.sv
// Directed bench for the two-digit BCD counter with DEB_CYCLES=4, one instance
// at MAX_VAL=99 and one at MAX_VAL=59.
module tb_bcd_updown_counter_2d;

    logic       clk = 1'b0;
    logic       rst;
    logic       up, dn, clr;
    logic [3:0] bcd1, bcd0;
    logic       wrap, borrow;

    logic       up59, dn59, clr59;
    logic [3:0] bcd1_59, bcd0_59;
    logic       wrap59, borrow59;

    int n_checks = 0;
    int n_pass   = 0;
    int wrap_n = 0, borrow_n = 0, wrap59_n = 0, borrow59_n = 0;
    int w0, b0;

    always #5 clk = ~clk;

    bcd_updown_counter_2d #(.DEB_CYCLES(4), .MAX_VAL(99)) u_dut (
        .clk(clk), .rst(rst), .btn_up(up), .btn_dn(dn), .btn_clr(clr),
        .bcd1(bcd1), .bcd0(bcd0), .wrap(wrap), .borrow(borrow)
    );

    bcd_updown_counter_2d #(.DEB_CYCLES(4), .MAX_VAL(59)) u_dut59 (
        .clk(clk), .rst(rst), .btn_up(up59), .btn_dn(dn59), .btn_clr(clr59),
        .bcd1(bcd1_59), .bcd0(bcd0_59), .wrap(wrap59), .borrow(borrow59)
    );

    // Pulse-width counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (wrap)     wrap_n++;
        if (borrow)   borrow_n++;
        if (wrap59)   wrap59_n++;
        if (borrow59) borrow59_n++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Press lands 7 edges after the first sampling edge; release fully settles in 7 more.
    task automatic press(input logic u, input logic d, input logic c);
        up = u; dn = d; clr = c;
        tick(7);
        up = 1'b0; dn = 1'b0; clr = 1'b0;
        tick(7);
    endtask

    task automatic press_up_n(input int n);
        for (int i = 0; i < n; i++) press(1'b1, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] val();
        return 32'({bcd1, bcd0});
    endfunction

    function automatic logic [31:0] val59();
        return 32'({bcd1_59, bcd0_59});
    endfunction

    initial begin
        rst = 1'b0;
        up = 1'b0; dn = 1'b0; clr = 1'b0;
        up59 = 1'b0; dn59 = 1'b0; clr59 = 1'b0;
        tick(3);
        check("reset_val", val(), 32'h00);
        check("reset_wrap", 32'(wrap), 32'd0);
        check("reset_borrow", 32'(borrow), 32'd0);
        rst = 1'b1;
        tick(2);

        // MAX_VAL=59: 00 dn -> 59 with borrow, then up -> 00 with wrap
        dn59 = 1'b1;
        tick(6);
        check("m59_pre_land", val59(), 32'h00);
        tick(1);
        check("m59_dn_borrow", val59(), 32'h59);
        dn59 = 1'b0;
        tick(7);
        check("m59_borrow_pulses", 32'(borrow59_n), 32'd1);
        up59 = 1'b1;
        tick(7);
        up59 = 1'b0;
        tick(7);
        check("m59_up_wrap", val59(), 32'h00);
        check("m59_wrap_pulses", 32'(wrap59_n), 32'd1);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold high
        for (int i = 0; i < 10; i++) begin
            up = (i % 2 == 0);
            tick(2);
        end
        check("bounce_no_count", val(), 32'h00);
        up = 1'b1;
        tick(6);
        check("bounce_edge6", val(), 32'h00);
        tick(1);
        check("bounce_edge7", val(), 32'h01);
        up = 1'b0;
        tick(7);

        // Hold: one press only, no auto-repeat
        press_up_n(4);
        check("to_05", val(), 32'h05);
        up = 1'b1;
        tick(1000);
        check("hold_06", val(), 32'h06);
        up = 1'b0;
        tick(7);
        press_up_n(1);
        check("repress_07", val(), 32'h07);

        // Carry and digit borrow
        press_up_n(2);
        check("to_09", val(), 32'h09);
        press_up_n(1);
        check("carry_10", val(), 32'h10);
        press(1'b0, 1'b1, 1'b0);
        check("borrow_09", val(), 32'h09);
        press_up_n(1);
        check("back_10", val(), 32'h10);

        // Simultaneous presses
        press_up_n(32);
        check("to_42", val(), 32'h42);
        w0 = wrap_n;
        b0 = borrow_n;
        press(1'b1, 1'b1, 1'b0);
        check("updn_hold_42", val(), 32'h42);
        check("updn_no_wrap", 32'(wrap_n), 32'(w0));
        check("updn_no_borrow", 32'(borrow_n), 32'(b0));
        press(1'b1, 1'b1, 1'b1);
        check("clr_wins_00", val(), 32'h00);

        // 00 dn -> 99 with borrow, 99 up -> 00 with wrap, one cycle each
        press(1'b0, 1'b1, 1'b0);
        check("dn_00_to_99", val(), 32'h99);
        check("borrow_one_cycle", 32'(borrow_n), 32'(b0 + 1));
        check("no_wrap_on_dn", 32'(wrap_n), 32'(w0));
        press_up_n(1);
        check("up_99_to_00", val(), 32'h00);
        check("wrap_one_cycle", 32'(wrap_n), 32'(w0 + 1));

        // Asynchronous reset mid-count at 37
        press_up_n(37);
        check("to_37", val(), 32'h37);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_val", val(), 32'h00);
        check("async_rst_wrap", 32'(wrap), 32'd0);
        check("async_rst_borrow", 32'(borrow), 32'd0);

        // Button held through reset release counts once, DEB_CYCLES+3 edges later
        up = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(6);
        check("held_rst_edge6", val(), 32'h00);
        tick(1);
        check("held_rst_edge7", val(), 32'h01);
        up = 1'b0;
        tick(7);
        check("held_rst_once", val(), 32'h01);

        // Reset mid-debounce leaves nothing pending
        up = 1'b1;
        tick(3);
        rst = 1'b0;
        up = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(10);
        check("mid_deb_rst", val(), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
